pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, 12, program-counter width in bits.
REQ-002 Parameter OFF_W, 8, branch-offset width in bits; the offset is two's complement.
REQ-003 Parameter STACK_DEPTH, 8, number of return-address entries; minimum 2.
REQ-004 Parameter RESET_VEC, 0, PC value loaded at reset.
REQ-005 Parameter INT_VEC, 'h001, PC value loaded on interrupt entry.
REQ-006 The block SHALL use one clock and an asynchronous active-low reset: clk_i first, rst_ni second.
REQ-007 clk_i  in  1  rising-edge clock.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 valid_i  in  1  instruction retires this cycle; PC advances only when high.
REQ-010 pcop_i  in  4  operation select (see REQ-016).
REQ-011 zero_i / carry_i  in  1 each  ALU flags for conditional branches.
REQ-012 offset_i  in  OFF_W  branch offset.
REQ-013 addr_i  in  PC_W  absolute jump or call target.
REQ-014 int_req_i  in  1  level interrupt request.
REQ-015 Outputs: pc_o (PC_W) current PC; in_isr_o (1) in service; int_ack_o (1) one-cycle entry pulse; stack_full_o / stack_empty_o (1 each); ovf_o / unf_o (1 each) sticky overflow/underflow flags.

Function
REQ-016 pcop_i encodings: 0000 SEQ, 0100 BZ, 0101 BNZ, 0110 BC, 0111 BNC, 1000 JMP, 1001 JSB, 1010 RET, 1100 RETI; any other value SHALL behave as SEQ.
REQ-017 nxt SHALL be PC+1 for SEQ, for an untaken branch, and for an unused code.
REQ-018 nxt for a taken branch SHALL be PC + sign-extended offset_i, with BZ taken on zero_i=1, BNZ on zero_i=0, BC on carry_i=1, BNC on carry_i=0.
REQ-019 nxt SHALL be addr_i for JMP and JSB, the top of stack for RET, and the saved interrupt PC for RETI.
REQ-020 All PC arithmetic SHALL wrap modulo 2^PC_W.
REQ-021 When valid_i=0, the PC, stack, state and flags SHALL hold.
REQ-022 When valid_i=1, pc_o SHALL take the value of nxt on the next rising edge (single-cycle latency).
REQ-023 JSB SHALL push PC+1. If the stack is full, JSB SHALL NOT push, SHALL set ovf_o and SHALL still jump.
REQ-024 RET SHALL pop the stack. If the stack is empty, RET SHALL set unf_o and nxt SHALL be PC+1.
REQ-025 The FSM SHALL have two states, RUN and ISR; in_isr_o SHALL be 1 exactly in ISR.
REQ-026 RUN->ISR SHALL occur when valid_i=1 and int_req_i=1. On this transition:
- the computed nxt SHALL be saved as the interrupt PC;
- pc_o SHALL load INT_VEC;
- int_ack_o SHALL pulse for one cycle;
- the stack effect of the retiring instruction SHALL still apply.
REQ-027 In ISR, int_req_i SHALL be ignored; there is no nesting.
REQ-028 ISR->RUN SHALL occur on a retired RETI, which loads the saved interrupt PC.
REQ-029 RETI in RUN SHALL behave as SEQ.
REQ-030 stack_full_o and stack_empty_o SHALL reflect the occupancy registered after each edge.
REQ-031 ovf_o and unf_o SHALL clear only on reset.

Reset
REQ-032 On rst_ni=0, asynchronously:
- pc_o=RESET_VEC;
- state=RUN;
- stack empty: stack_empty_o=1, stack_full_o=0;
- saved interrupt PC=0;
- int_ack_o, in_isr_o, ovf_o and unf_o =0.
REQ-033 Reset asserted mid-ISR or mid-call SHALL discard all stack contents and ISR context.

Structure
REQ-034 A shared package pc_pkg SHALL hold:
- the pcop_e enum (4-bit encodings of REQ-016);
- the state_e enum (RUN, ISR).
REQ-035 The return stack SHALL be a sub-module ret_stack, parametrised by width and depth, with push/pop/full/empty ports and a registered pointer.

Verification
REQ-036 Branch wrap: PC=0xFFE, BNZ, zero_i=0, offset=0x05 -> pc_o=0x003; same with zero_i=1 -> 0xFFF.
REQ-037 Negative offset: PC=0x010, BC, carry_i=1, offset=0xF0 -> pc_o=0x000.
REQ-038 Call/return: PC=0x020, JSB addr=0x300 -> pc_o=0x300, then RET -> pc_o=0x021, with stack_empty_o=1 after the RET.
REQ-039 Stack limits, case 1: nine nested JSB with STACK_DEPTH=8 -> ovf_o=1 after the ninth, and eight RETs return correctly.
REQ-040 Stack limits, case 2: a RET on an empty stack -> unf_o=1 and pc_o=PC+1.
REQ-041 Interrupt path, entry: int_req_i=1 while PC=0x040 retires SEQ -> pc_o=0x001, int_ack_o pulses once, in_isr_o=1.
REQ-042 Interrupt path, in service: a second int_req_i during ISR is ignored.
REQ-043 Interrupt path, exit: RETI -> pc_o=0x041, in_isr_o=0.
REQ-044 Stall and reset: valid_i=0 for 5 cycles -> pc_o unchanged.
REQ-045 Mid-ISR reset: rst_ni pulsed during ISR -> pc_o=0x000, in_isr_o=0, stack_empty_o=1, all flags=0, with the outputs changing before the next clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
package pc_pkg;

  // PC operation encodings; any code not listed here behaves as PcopSeq.
  typedef enum logic [3:0] {
    PcopSeq  = 4'b0000,
    PcopBz   = 4'b0100,
    PcopBnz  = 4'b0101,
    PcopBc   = 4'b0110,
    PcopBnc  = 4'b0111,
    PcopJmp  = 4'b1000,
    PcopJsb  = 4'b1001,
    PcopRet  = 4'b1010,
    PcopReti = 4'b1100
  } pcop_e;

  // Sequencer mode: normal execution or interrupt service.
  typedef enum logic [0:0] {
    StRun = 1'b0,
    StIsr = 1'b1
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack with a registered occupancy pointer.
// Push on full and pop on empty are ignored; the caller flags them.
module ret_stack #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [PW-1:0]    ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_idx;

  // Status and top-of-stack view derived from the registered pointer.
  always_comb begin
    full_o  = (ptr_q == PW'(DEPTH));
    empty_o = (ptr_q == '0);
    top_idx = ptr_q - PW'(1);
    top_o   = mem_q[top_idx[IW-1:0]];
  end

  // Storage and pointer update; reset discards every entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      mem_q[ptr_q[IW-1:0]] <= data_i;
      ptr_q                <= ptr_q + PW'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q <= ptr_q - PW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branches, jumps, call/return stack and a
// single-level interrupt with saved return PC.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     PC_W        = 12,
  parameter int unsigned     OFF_W       = 8,
  parameter int unsigned     STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter logic [PC_W-1:0] INT_VEC     = 'h001
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [3:0]       pcop_i,
  input  logic             zero_i,
  input  logic             carry_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [PC_W-1:0]  addr_i,
  input  logic             int_req_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             in_isr_o,
  output logic             int_ack_o,
  output logic             stack_full_o,
  output logic             stack_empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] int_pc_q, int_pc_d;
  logic            int_ack_q, int_ack_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  pcop_e           op;
  logic [PC_W-1:0] pc_inc, pc_br, nxt, stack_top;
  logic            push, pop, take_int;

  assign op = pcop_e'(pcop_i);

  ret_stack #(
    .WIDTH(PC_W),
    .DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .pop_i  (pop),
    .data_i (pc_inc),
    .top_o  (stack_top),
    .full_o (stack_full_o),
    .empty_o(stack_empty_o)
  );

  // Next-PC selection, stack control, flag and FSM next-state.
  always_comb begin
    pc_inc    = pc_q + PC_W'(1);
    pc_br     = pc_q + {{(PC_W - OFF_W){offset_i[OFF_W-1]}}, offset_i};
    nxt       = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    state_d   = state_q;
    int_pc_d  = int_pc_q;
    int_ack_d = 1'b0;
    pc_d      = pc_q;
    take_int  = 1'b0;

    unique case (op)
      PcopBz:  if (zero_i)   nxt = pc_br;
      PcopBnz: if (!zero_i)  nxt = pc_br;
      PcopBc:  if (carry_i)  nxt = pc_br;
      PcopBnc: if (!carry_i) nxt = pc_br;
      PcopJmp: nxt = addr_i;
      PcopJsb: begin
        nxt = addr_i;
        if (stack_full_o) ovf_d = valid_i ? 1'b1 : ovf_q;
        else              push  = valid_i;
      end
      PcopRet: begin
        if (stack_empty_o) begin
          unf_d = valid_i ? 1'b1 : unf_q;
        end else begin
          pop = valid_i;
          nxt = stack_top;
        end
      end
      PcopReti: begin
        // Outside service RETI is just a sequential step.
        if (state_q == StIsr) begin
          nxt = int_pc_q;
          if (valid_i) state_d = StRun;
        end
      end
      default: nxt = pc_inc;
    endcase

    if (valid_i) begin
      pc_d     = nxt;
      take_int = (state_q == StRun) && int_req_i;
      if (take_int) begin
        int_pc_d  = nxt;
        pc_d      = INT_VEC;
        state_d   = StIsr;
        int_ack_d = 1'b1;
      end
    end
  end

  // State, PC, saved interrupt PC and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      pc_q      <= RESET_VEC;
      int_pc_q  <= '0;
      int_ack_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      int_pc_q  <= int_pc_d;
      int_ack_q <= int_ack_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign pc_o      = pc_q;
  assign in_isr_o  = (state_q == StIsr);
  assign int_ack_o = int_ack_q;
  assign ovf_o     = ovf_q;
  assign unf_o     = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  pcop;
  logic        zero, carry;
  logic [7:0]  offset;
  logic [11:0] addr;
  logic        int_req;
  logic [11:0] pc;
  logic        in_isr, int_ack, stack_full, stack_empty, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] SEQ = 4'b0000, BZ = 4'b0100, BNZ = 4'b0101, BC = 4'b0110,
                         BNC = 4'b0111, JMP = 4'b1000, JSB = 4'b1001, RET = 4'b1010,
                         RETI = 4'b1100;

  pc_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid),
    .pcop_i       (pcop),
    .zero_i       (zero),
    .carry_i      (carry),
    .offset_i     (offset),
    .addr_i       (addr),
    .int_req_i    (int_req),
    .pc_o         (pc),
    .in_isr_o     (in_isr),
    .int_ack_o    (int_ack),
    .stack_full_o (stack_full),
    .stack_empty_o(stack_empty),
    .ovf_o        (ovf),
    .unf_o        (unf)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    valid   = 1'b0;
    int_req = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Retire one instruction at the next edge; outputs are stable on return.
  task automatic exec(input logic [3:0] op, input logic [11:0] a, input logic [7:0] off,
                      input logic z, input logic c, input logic irq);
    pcop = op; addr = a; offset = off; zero = z; carry = c; int_req = irq;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid   = 1'b0;
    int_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc got=%h exp=000", pc); end
    n_checks++;
    if ({in_isr, int_ack, stack_full, stack_empty, ovf, unf} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_flags got=%b exp=000100",
               {in_isr, int_ack, stack_full, stack_empty, ovf, unf});
    end
  endtask

  task automatic test_branch();
    apply_reset();
    exec(JMP, 12'hFFE, 8'h00, 0, 0, 0);
    exec(BNZ, 12'h000, 8'h05, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h003) begin n_fail++; $display("FAIL bnz_wrap got=%h exp=003", pc); end
    exec(JMP, 12'hFFE, 8'h00, 0, 0, 0);
    exec(BNZ, 12'h000, 8'h05, 1, 0, 0);
    n_checks++;
    if (pc !== 12'hFFF) begin n_fail++; $display("FAIL bnz_untaken got=%h exp=fff", pc); end
    exec(BZ, 12'h000, 8'h10, 1, 0, 0);
    n_checks++;
    if (pc !== 12'h00F) begin n_fail++; $display("FAIL bz_taken got=%h exp=00f", pc); end
    exec(JMP, 12'h010, 8'h00, 0, 0, 0);
    exec(BC, 12'h000, 8'hF0, 0, 1, 0);
    n_checks++;
    if (pc !== 12'h000) begin n_fail++; $display("FAIL bc_neg got=%h exp=000", pc); end
    exec(BNC, 12'h000, 8'h20, 0, 1, 0);
    n_checks++;
    if (pc !== 12'h001) begin n_fail++; $display("FAIL bnc_untaken got=%h exp=001", pc); end
    exec(BNC, 12'h000, 8'h20, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h021) begin n_fail++; $display("FAIL bnc_taken got=%h exp=021", pc); end
    exec(4'b0011, 12'h7AA, 8'h40, 1, 1, 0);
    n_checks++;
    if (pc !== 12'h022) begin n_fail++; $display("FAIL unused_op got=%h exp=022", pc); end
    exec(RETI, 12'h7AA, 8'h40, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h023 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL reti_in_run got=%h/%b exp=023/0", pc, in_isr);
    end
  endtask

  task automatic test_call_return();
    apply_reset();
    exec(JMP, 12'h020, 8'h00, 0, 0, 0);
    exec(JSB, 12'h300, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h300 || stack_empty !== 1'b0) begin
      n_fail++; $display("FAIL jsb got=%h empty=%b exp=300 empty=0", pc, stack_empty);
    end
    exec(RET, 12'h555, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h021 || stack_empty !== 1'b1) begin
      n_fail++; $display("FAIL ret got=%h empty=%b exp=021 empty=1", pc, stack_empty);
    end
  endtask

  task automatic test_stack_limits();
    logic [11:0] site;
    apply_reset();
    exec(JMP, 12'h100, 8'h00, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      exec(JSB, 12'h200 + 12'(i * 16), 8'h00, 0, 0, 0);
    end
    n_checks++;
    if (pc !== 12'h280 || stack_full !== 1'b1 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow got pc=%h full=%b ovf=%b exp 280/1/1", pc, stack_full, ovf);
    end
    for (int k = 7; k >= 0; k--) begin
      site = (k == 0) ? 12'h100 : 12'h200 + 12'((k - 1) * 16);
      exec(RET, 12'h000, 8'h00, 0, 0, 0);
      n_checks++;
      if (pc !== site + 12'h001) begin
        n_fail++; $display("FAIL ret_%0d got=%h exp=%h", k, pc, site + 12'h001);
      end
    end
    n_checks++;
    if (stack_empty !== 1'b1 || unf !== 1'b0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL after_rets got empty=%b unf=%b ovf=%b exp 1/0/1", stack_empty, unf, ovf);
    end
    exec(RET, 12'h777, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h102 || unf !== 1'b1) begin
      n_fail++; $display("FAIL underflow got pc=%h unf=%b exp 102/1", pc, unf);
    end
  endtask

  task automatic test_interrupt();
    apply_reset();
    exec(JMP, 12'h040, 8'h00, 0, 0, 0);
    exec(SEQ, 12'h000, 8'h00, 0, 0, 1);
    n_checks++;
    if (pc !== 12'h001 || int_ack !== 1'b1 || in_isr !== 1'b1) begin
      n_fail++;
      $display("FAIL int_entry got pc=%h ack=%b isr=%b exp 001/1/1", pc, int_ack, in_isr);
    end
    exec(SEQ, 12'h000, 8'h00, 0, 0, 1);
    n_checks++;
    if (pc !== 12'h002 || int_ack !== 1'b0 || in_isr !== 1'b1) begin
      n_fail++;
      $display("FAIL int_nested got pc=%h ack=%b isr=%b exp 002/0/1", pc, int_ack, in_isr);
    end
    exec(RETI, 12'h000, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h041 || in_isr !== 1'b0 || int_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reti got pc=%h isr=%b ack=%b exp 041/0/0", pc, in_isr, int_ack);
    end
    // Interrupt taken on a retiring call: the push still lands.
    exec(JMP, 12'h050, 8'h00, 0, 0, 0);
    exec(JSB, 12'h300, 8'h00, 0, 0, 1);
    n_checks++;
    if (pc !== 12'h001 || stack_empty !== 1'b0) begin
      n_fail++; $display("FAIL int_on_jsb got pc=%h empty=%b exp 001/0", pc, stack_empty);
    end
    exec(RETI, 12'h000, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h300) begin n_fail++; $display("FAIL reti_to_call got=%h exp=300", pc); end
    exec(RET, 12'h000, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h051) begin n_fail++; $display("FAIL ret_after_isr got=%h exp=051", pc); end
  endtask

  task automatic test_stall();
    apply_reset();
    exec(JMP, 12'h123, 8'h00, 0, 0, 0);
    pcop = JMP; addr = 12'h555; int_req = 1'b1; valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (pc !== 12'h123 || in_isr !== 1'b0) begin
        n_fail++; $display("FAIL stall_%0d got pc=%h isr=%b exp 123/0", i, pc, in_isr);
      end
    end
    int_req = 1'b0;
  endtask

  task automatic test_mid_isr_reset();
    apply_reset();
    exec(RET, 12'h000, 8'h00, 0, 0, 0);
    exec(JSB, 12'h200, 8'h00, 0, 0, 0);
    exec(SEQ, 12'h000, 8'h00, 0, 0, 1);
    n_checks++;
    if (in_isr !== 1'b1 || unf !== 1'b1 || stack_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset got isr=%b unf=%b empty=%b exp 1/1/0", in_isr, unf, stack_empty);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (pc !== 12'h000 || {in_isr, int_ack, stack_full, stack_empty, ovf, unf} !== 6'b000100)
    begin
      n_fail++;
      $display("FAIL async_reset got pc=%h flags=%b exp 000/000100", pc,
               {in_isr, int_ack, stack_full, stack_empty, ovf, unf});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exec(RETI, 12'h000, 8'h00, 0, 0, 0);
    n_checks++;
    if (pc !== 12'h001 || in_isr !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_reti got pc=%h isr=%b exp 001/0", pc, in_isr);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; pcop = SEQ; zero = 1'b0; carry = 1'b0;
    offset = '0; addr = '0; int_req = 1'b0;
    test_reset();
    test_branch();
    test_call_return();
    test_stack_limits();
    test_interrupt();
    test_stall();
    test_mid_isr_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
